// File: rtl/parallel2serial_if.sv
// Bus bundle for the parallel-to-serial transmitter.
//   in_valid / in_p1 / in_p2 : word offered by the producer
//   in_ready                 : transmitter holding buffer is empty
//   srl                      : serial output line
//   frame_start              : srl carries bit 0 of a frame
//   underrun                 : current frame is a fill frame
//   tx_count                 : number of data frames loaded (wraps)
// Modports: master = word producer, slave = transmitter.
interface parallel2serial_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [1:0]       in_p1;
    logic [1:0]       in_p2;
    logic             in_ready;
    logic             srl;
    logic             frame_start;
    logic             underrun;
    logic [CNT_W-1:0] tx_count;

    modport master (
        output in_valid, in_p1, in_p2,
        input  in_ready, srl, frame_start, underrun, tx_count
    );

    modport slave (
        input  in_valid, in_p1, in_p2,
        output in_ready, srl, frame_start, underrun, tx_count
    );
endinterface

// File: rtl/parallel2serial.sv
// Parallel-to-serial transmitter.
// Emits gap-free 4-bit frames on srl (bit order in_p1[1], in_p2[1],
// in_p1[0], in_p2[0]) from a one-entry holding buffer. When the buffer is
// empty at a frame boundary a fill frame is sent and underrun is raised.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : parallel2serial_if.slave (handshake, serial line, status)
// Optional feature: define P2S_REPEAT_LAST_EN to make the fill frame repeat
// the last data frame loaded (all zeros until one has been loaded).
module parallel2serial #(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    parallel2serial_if.slave    bus
);
    // Slot within the frame; SLOT_0 is the cycle srl shows bit 0.
    typedef enum logic [1:0] {
        SLOT_0 = 2'd0,
        SLOT_1 = 2'd1,
        SLOT_2 = 2'd2,
        SLOT_3 = 2'd3
    } slot_t;

    slot_t            slot_reg, slot_next;
    logic [3:0]       shift_reg, shift_next;
    logic             buf_full_reg, buf_full_next;
    logic [3:0]       buf_data_reg, buf_data_next;
    logic             underrun_reg, underrun_next;
    logic [CNT_W-1:0] tx_count_reg, tx_count_next;
    logic [3:0]       fill_frame;
    logic             accept;

`ifdef P2S_REPEAT_LAST_EN
    logic [3:0]       last_reg, last_next;
    assign fill_frame = last_reg;
`else
    assign fill_frame = 4'b0000;
`endif

    // Only possible while the buffer is empty, so it never collides with
    // the buffer being released on a slot-3 edge.
    assign accept = bus.in_valid && !buf_full_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_reg     <= SLOT_0;
            shift_reg    <= 4'b0000;
            buf_full_reg <= 1'b0;
            buf_data_reg <= 4'b0000;
            underrun_reg <= 1'b1;
            tx_count_reg <= '0;
`ifdef P2S_REPEAT_LAST_EN
            last_reg     <= 4'b0000;
`endif
        end else begin
            slot_reg     <= slot_next;
            shift_reg    <= shift_next;
            buf_full_reg <= buf_full_next;
            buf_data_reg <= buf_data_next;
            underrun_reg <= underrun_next;
            tx_count_reg <= tx_count_next;
`ifdef P2S_REPEAT_LAST_EN
            last_reg     <= last_next;
`endif
        end
    end

    always_comb begin
        slot_next     = slot_reg;
        shift_next    = shift_reg;
        buf_full_next = buf_full_reg;
        buf_data_next = buf_data_reg;
        underrun_next = underrun_reg;
        tx_count_next = tx_count_reg;
`ifdef P2S_REPEAT_LAST_EN
        last_next     = last_reg;
`endif

        case (slot_reg)
            SLOT_3: begin
                slot_next = SLOT_0;
                if (buf_full_reg) begin
                    shift_next    = buf_data_reg;
                    buf_full_next = 1'b0;
                    underrun_next = 1'b0;
                    tx_count_next = tx_count_reg + CNT_W'(1);
`ifdef P2S_REPEAT_LAST_EN
                    last_next     = buf_data_reg;
`endif
                end else begin
                    shift_next    = fill_frame;
                    underrun_next = 1'b1;
                end
            end
            default: begin
                slot_next  = slot_t'(slot_reg + 2'd1);
                shift_next = {1'b0, shift_reg[3:1]};
            end
        endcase

        // A word accepted on a load edge lands in the buffer, never bypasses
        // it, so the frame being loaded on that edge stays a fill frame.
        if (accept) begin
            buf_full_next = 1'b1;
            buf_data_next = {bus.in_p2[0], bus.in_p1[0], bus.in_p2[1], bus.in_p1[1]};
        end
    end

    assign bus.srl         = shift_reg[0];
    assign bus.frame_start = (slot_reg == SLOT_0);
    assign bus.underrun    = underrun_reg;
    assign bus.in_ready    = !buf_full_reg;
    assign bus.tx_count    = tx_count_reg;
endmodule
